// File: rtl/uart_frame_scheduler.sv
// uart_frame_scheduler
// Shares one debug UART transmitter between the I2S sample stream and a
// byte-wide status source. Samples are optionally decimated, buffered in a
// small FIFO and sent as 4-byte sync-prefixed frames; status requests are
// sent as 2-byte frames. Arbitration only happens between frames, with a
// round-robin tie break, and each byte is handed over with a trigger/busy
// handshake.

module uart_frame_scheduler #(
  parameter int         FIFO_DEPTH  = 8,
  parameter int         DECIMATE    = 1,
  parameter logic [7:0] SAMPLE_SYNC = 8'hA5,
  parameter logic [7:0] STATUS_SYNC = 8'h5A
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          enable_in,
  input  logic [23:0]                   sample_in,
  input  logic                          sample_valid_in,
  input  logic [7:0]                    status_in,
  input  logic                          status_req_in,
  output logic                          status_ack_out,
  input  logic                          tx_busy_in,
  output logic [7:0]                    tx_byte_out,
  output logic                          tx_trigger_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
  output logic [15:0]                   overflow_count_out,
  output logic                          frame_active_out
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam int          LW       = AW + 1;
  localparam logic [15:0] DEC_LAST = 16'(DECIMATE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRE,
    ST_GUARD,
    ST_WAIT
  } state_t;

  state_t         state;
  state_t         next_state;

  logic [15:0]    dec_cnt;
  logic [23:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  logic           capture;
  logic           push_req;
  logic           push_ok;
  logic           pop;
  logic           drop;
  logic           fifo_full;
  logic           fifo_empty;

  logic           grant_sample;
  logic           grant_status;
  logic           load_byte;
  logic           frame_done;
  logic [1:0]     byte_idx;
  logic [1:0]     next_idx;
  logic [1:0]     last_idx;
  logic [7:0]     next_byte;

  logic [23:0]    frame_data;
  logic           frame_is_status;
  logic           last_was_status;

  assign capture    = enable_in & sample_valid_in;
  assign push_req   = capture & (dec_cnt == DEC_LAST);
  assign fifo_full  = (fifo_level_out == LW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_level_out == '0);
  assign pop        = grant_sample;
  // A full FIFO still takes a sample when the grant frees a slot that cycle.
  assign push_ok    = push_req & (~fifo_full | pop);
  assign drop       = push_req & fifo_full & ~pop;
  assign last_idx   = frame_is_status ? 2'd1 : 2'd3;

  // Decimation counter: advances on every accepted strobe, wraps after the pushing one.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      dec_cnt <= '0;
    end else if (capture) begin
      dec_cnt <= (dec_cnt == DEC_LAST) ? 16'd0 : dec_cnt + 16'd1;
    end
  end

  // Sample storage; contents need no reset because the pointers qualify them.
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= sample_in;
    end
  end

  // FIFO pointers, occupancy and saturating drop counter.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      fifo_level_out     <= '0;
      overflow_count_out <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   fifo_level_out <= fifo_level_out + LW'(1);
        2'b01:   fifo_level_out <= fifo_level_out - LW'(1);
        default: fifo_level_out <= fifo_level_out;
      endcase
      if (drop && (overflow_count_out != 16'hFFFF)) begin
        overflow_count_out <= overflow_count_out + 16'd1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic, grant decision and byte sequencing.
  always_comb begin
    next_state   = state;
    grant_sample = 1'b0;
    grant_status = 1'b0;
    load_byte    = 1'b0;
    frame_done   = 1'b0;
    next_idx     = byte_idx;
    case (state)
      ST_IDLE: begin
        if (enable_in) begin
          if (status_req_in && (fifo_empty || !last_was_status)) begin
            grant_status = 1'b1;
          end else if (!fifo_empty) begin
            grant_sample = 1'b1;
          end
        end
        if (grant_status || grant_sample) begin
          next_state = ST_FIRE;
          next_idx   = 2'd0;
          load_byte  = 1'b1;
        end
      end
      ST_FIRE: begin
        next_state = ST_GUARD;
      end
      ST_GUARD: begin
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (!tx_busy_in) begin
          if (byte_idx == last_idx) begin
            next_state = ST_IDLE;
            frame_done = 1'b1;
          end else begin
            next_state = ST_FIRE;
            next_idx   = byte_idx + 2'd1;
            load_byte  = 1'b1;
          end
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Byte that will be presented in the coming FIRE cycle.
  always_comb begin
    next_byte = 8'h00;
    if (grant_status) begin
      next_byte = STATUS_SYNC;
    end else if (grant_sample) begin
      next_byte = SAMPLE_SYNC;
    end else begin
      case (next_idx)
        2'd1:    next_byte = frame_is_status ? frame_data[7:0] : frame_data[23:16];
        2'd2:    next_byte = frame_data[15:8];
        2'd3:    next_byte = frame_data[7:0];
        default: next_byte = 8'h00;
      endcase
    end
  end

  // Frame register, registered transmitter outputs and round-robin flag.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      byte_idx         <= '0;
      frame_data       <= '0;
      frame_is_status  <= 1'b0;
      last_was_status  <= 1'b0;
      tx_byte_out      <= 8'h00;
      tx_trigger_out   <= 1'b0;
      status_ack_out   <= 1'b0;
      frame_active_out <= 1'b0;
    end else begin
      byte_idx       <= next_idx;
      tx_trigger_out <= load_byte;
      status_ack_out <= grant_status;
      if (load_byte) begin
        tx_byte_out <= next_byte;
      end
      if (grant_sample) begin
        frame_data      <= fifo_mem[rd_ptr];
        frame_is_status <= 1'b0;
        last_was_status <= 1'b0;
      end else if (grant_status) begin
        frame_data      <= {16'h0000, status_in};
        frame_is_status <= 1'b1;
        last_was_status <= 1'b1;
      end
      if (grant_sample || grant_status) begin
        frame_active_out <= 1'b1;
      end else if (frame_done) begin
        frame_active_out <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_frame_scheduler.md
# uart_frame_scheduler

Sequences and arbitrates the shared debug UART transmitter between two requesters: the 24-bit I2S microphone sample stream and a byte-wide status source. It sits between `i2s_receiver` (debug data/valid) and `uart_transmit` (data_byte_in/trigger_in/busy_out). Samples are buffered in a small FIFO, optionally decimated, and framed as sync-prefixed packets so the host can resynchronise. It drives the transmitter's trigger/busy handshake byte by byte.

## Interface
- `FIFO_DEPTH`, 8: sample FIFO entries; power of two, ≥2.
- `DECIMATE`, 1: forward every DECIMATE-th valid sample; 1 forwards all; range 1..65535.
- `SAMPLE_SYNC`, 8'hA5: first byte of a sample frame.
- `STATUS_SYNC`, 8'h5A: first byte of a status frame.

- `clk_in` input 1: system clock, 100 MHz.
- `rst_in` input 1: reset; one clock; reset is asynchronous and active-high.
- `enable_in` input 1: when low, no samples are captured and no new frames start.
- `sample_in` input 24: raw microphone word.
- `sample_valid_in` input 1: one-cycle strobe qualifying `sample_in`.
- `status_in` input 8: status byte; must be stable while `status_req_in` is high.
- `status_req_in` input 1: level request for a status frame.
- `status_ack_out` output 1: one-cycle pulse when the status frame is granted and `status_in` is captured.
- `tx_busy_in` input 1: transmitter busy.
- `tx_byte_out` output 8: byte to the transmitter.
- `tx_trigger_out` output 1: one-cycle start pulse to the transmitter.
- `fifo_level_out` output $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `overflow_count_out` output 16: dropped-sample count, saturating.
- `frame_active_out` output 1: high from grant until the last byte completes.

## Operation
- Capture: decimation counter counts accepted `sample_valid_in` strobes while `enable_in`=1. It pushes on the strobe where the count equals DECIMATE-1, then wraps to 0. With DECIMATE=1, every strobe pushes.
- Push when full without a same-cycle pop: drop the sample and increment `overflow_count_out`, saturating at 16'hFFFF. Push when full with a same-cycle pop is accepted; level is unchanged.
- Sample frame, 4 bytes: SAMPLE_SYNC, s[23:16], s[15:8], s[7:0].
- Status frame, 2 bytes: STATUS_SYNC, status byte.
- Arbitration happens only in IDLE, at frame boundaries. No frame is ever interleaved.
  - If only one requester is pending, it wins.
  - If both are pending, the one not served last wins (round-robin flag). The flag resets to "sample served last", so status wins the first tie.
- FSM states: IDLE, FIRE, GUARD, WAIT.
  - IDLE: if `enable_in` and a request is pending, grant. A sample grant pops the FIFO into the frame register; a status grant captures `status_in` and pulses `status_ack_out`. Set byte index to 0, raise `frame_active_out`, go to FIRE.
  - FIRE: `tx_trigger_out`=1 with the indexed byte on `tx_byte_out`, then go to GUARD.
  - GUARD: ignore `tx_busy_in` for one cycle, then go to WAIT.
  - WAIT: stay while `tx_busy_in`=1. When it is low, either increment the index and go to FIRE, or, if the last byte is done, drop `frame_active_out` and go to IDLE.
- `tx_byte_out` is registered and holds its value from FIRE until the next FIRE.
- `enable_in` falling mid-frame: the current frame completes; no new grant is made.
- `status_req_in` dropped before grant: no frame is sent.

## Timing
- Reset values: `tx_trigger_out` 0, `tx_byte_out` 8'h00, `status_ack_out` 0, `frame_active_out` 0, `fifo_level_out` 0, `overflow_count_out` 0. FIFO pointers, decimation counter and round-robin flag are also cleared. FSM resets to IDLE.
- Async reset mid-frame: outputs clear immediately. The partial frame is abandoned, and the host resyncs on the sync byte.
- Transmitter contract: `tx_busy_in` is high in the cycle after the trigger and stays high until the byte is complete.
- Latency with empty FIFO, IDLE state and idle transmitter:
  - Strobe in cycle 0 gives level 1 in cycle 1.
  - Grant in cycle 1 returns the level to 0 in cycle 2.
  - First trigger, with SAMPLE_SYNC, is in cycle 2.
- Trigger spacing is at least 3 cycles, and the next trigger comes at least 1 cycle after `tx_busy_in` is seen low.
- Frame-to-frame gap: after the last WAIT, IDLE takes one cycle, then the next frame's FIRE follows.

## Test plan
- Single sample 24'h123456, idle transmitter model with busy for 10 cycles → trigger bytes A5,12,34,56; trigger spacing 12 cycles; `fifo_level_out` returns to 0.
- 10 strobes back-to-back during one frame, FIFO_DEPTH=8 → 8 stored, `overflow_count_out`=2; the next 8 frames carry samples in order.
- Status request 8'hC3 held concurrently with a pending sample at reset → status frame 5A,C3 first, with `status_ack_out` pulsed once; then the sample frame; then alternating frames while both stay pending.
- DECIMATE=4, 12 strobes with values 0..11 → frames carry 3, 7, 11 only.
- Assert `rst_in` after the second byte of a frame → `tx_trigger_out` and `frame_active_out` go low immediately; all counters are 0; after release, a new sample produces a full frame starting with A5.
- Full FIFO with simultaneous pop and push → push accepted; level stays 8; overflow count unchanged.
